// File: rtl/sram_1r1w_init.sv
// rtl/sram_1r1w_init.sv - single-clock 1R1W SRAM model with lane mask, read pipeline and clear-on-reset
module sram_1r1w_init #(
  parameter int DEPTH         = 512,
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 64,
  parameter int MASK_GRAN     = 8,
  parameter int READ_LATENCY  = 1,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  localparam int MASK_W = DATA_W / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_busy,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Without a clear sequence the array comes up directly in RUN.
  localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              run, init_fire, wr_fire, rd_fire;
  logic              wr_in_range, rd_in_range;
  logic [DATA_W-1:0] bit_mask, wr_old, wr_word, rd_word;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;

  // Request qualification: reset and the clear sequence both swallow port traffic.
  always_comb begin
    run         = !reset && (state_q == ST_RUN);
    init_fire   = !reset && (state_q == ST_INIT);
    wr_in_range = {1'b0, W0_addr} < DEPTH_W;
    rd_in_range = {1'b0, R0_addr} < DEPTH_W;
    wr_fire     = run && W0_en && wr_in_range;
    rd_fire     = run && R0_en;
  end

  // Expand the lane mask and build the merged word that a write will store.
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < MASK_W; i++) begin
      bit_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
    end
    wr_old  = wr_in_range ? mem[W0_addr] : '0;
    wr_word = (wr_old & ~bit_mask) | (W0_data & bit_mask);
  end

  // Read lookup; out-of-range reads return zero, same-address writes forward when BYPASS is set.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if ((BYPASS != 0) && wr_fire && (W0_addr == R0_addr)) begin
        rd_word = wr_word;
      end else begin
        rd_word = mem[R0_addr];
      end
    end
  end

  // Clear sequencer next state: walk every word once, then hand over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sequencer state register; reset restarts the clear from word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);

  // Storage update: the clear owns the array while busy, otherwise the write port does.
  always_ff @(posedge clock) begin
    if (init_fire) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wr_fire) begin
      mem[W0_addr] <= wr_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              p_valid_q, p_valid_d;
      logic [DATA_W-1:0] p_data_q, p_data_d;

      // Extra pipeline stage; data only captured on an accepted read.
      always_comb begin
        p_valid_d = rd_fire;
        p_data_d  = rd_fire ? rd_word : p_data_q;
      end

      // Pipeline stage register, flushed by reset.
      always_ff @(posedge clock) begin
        if (reset) begin
          p_valid_q <= 1'b0;
          p_data_q  <= '0;
        end else begin
          p_valid_q <= p_valid_d;
          p_data_q  <= p_data_d;
        end
      end

      assign beat_valid = p_valid_q;
      assign beat_data  = p_data_q;
    end else begin : g_lat1
      assign beat_valid = rd_fire;
      assign beat_data  = rd_word;
    end
  endgenerate

  // Output stage: data moves only on a valid beat and is held otherwise.
  always_comb begin
    r_valid_d = beat_valid;
    r_data_d  = beat_valid ? beat_data : r_data_q;
  end

  // Output register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign R0_valid = r_valid_q;
  assign R0_data  = r_data_q;

endmodule

// File: tb/tb_sram_1r1w_init.sv
// tb/tb_sram_1r1w_init.sv - randomized self-checking bench for sram_1r1w_init (two configurations in parallel)
module tb_sram_1r1w_init;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [8:0]  w_addr;
  logic [63:0] w_data;
  logic [7:0]  w_mask;
  logic        r_en;
  logic [8:0]  r_addr;

  logic [1:0]        busy;
  logic [1:0]        r_valid;
  logic [1:0][63:0]  r_data;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  logic [63:0] mdl [2][512];
  int          init_left [2];
  logic [63:0] exp_d [2][$];
  int          exp_c [2][$];
  logic [63:0] cap_d [2][$];
  int          cap_c [2][$];

  // u=0: 512 words, latency 1, bypass, fill A5..; u=1: 300 words, latency 2, no bypass, fill 0
  sram_1r1w_init #(
    .DEPTH(512), .ADDR_W(9), .DATA_W(64), .MASK_GRAN(8), .READ_LATENCY(1),
    .BYPASS(1), .INIT_ON_RESET(1), .INIT_VALUE(64'hA5A5_A5A5_A5A5_A5A5)
  ) dut_a (
    .clock(clk), .reset(rst), .init_busy(busy[0]),
    .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
    .R0_en(r_en), .R0_addr(r_addr), .R0_data(r_data[0]), .R0_valid(r_valid[0])
  );

  sram_1r1w_init #(
    .DEPTH(300), .ADDR_W(9), .DATA_W(64), .MASK_GRAN(8), .READ_LATENCY(2),
    .BYPASS(0), .INIT_ON_RESET(1), .INIT_VALUE(64'h0)
  ) dut_b (
    .clock(clk), .reset(rst), .init_busy(busy[1]),
    .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
    .R0_en(r_en), .R0_addr(r_addr), .R0_data(r_data[1]), .R0_valid(r_valid[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (r_valid[u] === 1'b1) begin
        cap_d[u].push_back(r_data[u]);
        cap_c[u].push_back(cyc);
      end
    end
  end

  function automatic int depth_of(input int u);
    return (u == 0) ? 512 : 300;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  function automatic logic [63:0] initv_of(input int u);
    return (u == 0) ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'h0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One clock: apply inputs, advance the reference model, step past the edge.
  task automatic cycle(input logic r, input logic we, input logic [8:0] wa, input logic [63:0] wd,
                       input logic [7:0] wm, input logic re, input logic [8:0] ra);
    rst = r; w_en = we; w_addr = wa; w_data = wd; w_mask = wm; r_en = re; r_addr = ra;
    for (int u = 0; u < 2; u++) begin
      logic [63:0] v;
      if (r) begin
        init_left[u] = depth_of(u);
      end else if (init_left[u] > 0) begin
        init_left[u]--;
        if (init_left[u] == 0) for (int a = 0; a < 512; a++) mdl[u][a] = initv_of(u);
      end else begin
        if (re) begin
          if (int'(ra) >= depth_of(u)) v = 64'h0;
          else begin
            v = mdl[u][ra];
            if (u == 0 && we && wa == ra) v = merge(v, wd, wm);
          end
          exp_d[u].push_back(v);
          exp_c[u].push_back(cyc + lat_of(u));
        end
        if (we && int'(wa) < depth_of(u)) mdl[u][wa] = merge(mdl[u][wa], wd, wm);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
  endtask

  task automatic flush_q();
    for (int u = 0; u < 2; u++) begin
      exp_d[u].delete(); exp_c[u].delete(); cap_d[u].delete(); cap_c[u].delete();
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 9'd7, 64'hFFFF_0000_FFFF_0000, 8'hFF, 1'b1, 9'd7);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (busy[u] !== 1'b1 || r_valid[u] !== 1'b0 || r_data[u] !== 64'h0)
          $display("FAIL reset u%0d: busy=%b valid=%b data=%h want busy=1 valid=0 data=0",
                   u, busy[u], r_valid[u], r_data[u]);
        else passed++;
      end
    end
  endtask

  task automatic test_clear();
    int cnt [2];
    cnt[0] = 0; cnt[1] = 0;
    flush_q();
    for (int k = 0; k < 700 && busy != 2'b00; k++) begin
      for (int u = 0; u < 2; u++) if (busy[u] === 1'b1) cnt[u]++;
      if (k == 10) cycle(1'b0, 1'b1, 9'd7, 64'h1234, 8'hFF, 1'b1, 9'd7);
      else idle(1);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cnt[u] != depth_of(u)) $display("FAIL clear_busy_len u%0d: got %0d want %0d", u, cnt[u], depth_of(u));
      else passed++;
      checks++;
      if (cap_d[u].size() != 0) $display("FAIL clear_drop_valid u%0d: got %0d beats want 0", u, cap_d[u].size());
      else passed++;
    end
    flush_q();
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd0);
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd255);
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd511);
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd7);
    idle(4);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cap_d[u].size() != 4) $display("FAIL clear_beats u%0d: got %0d want 4", u, cap_d[u].size());
      else passed++;
      for (int i = 0; i < 4 && i < cap_d[u].size(); i++) begin
        checks++;
        if (cap_d[u][i] !== initv_of(u) || cap_c[u][i] != exp_c[u][i])
          $display("FAIL clear_read u%0d #%0d: got %h @%0d want %h @%0d", u, i, cap_d[u][i], cap_c[u][i], initv_of(u), exp_c[u][i]);
        else passed++;
      end
    end
  endtask

  task automatic test_masked();
    flush_q();
    cycle(1'b0, 1'b1, 9'd3, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 9'd0);
    cycle(1'b0, 1'b1, 9'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 9'd0);
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd3);
    idle(4);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cap_d[u].size() != 1) $display("FAIL masked_beats u%0d: got %0d want 1", u, cap_d[u].size());
      else if (cap_d[u][0] !== 64'h1122_3344_FFFF_FFFF)
        $display("FAIL masked_data u%0d: got %h want %h", u, cap_d[u][0], 64'h1122_3344_FFFF_FFFF);
      else passed++;
    end
  endtask

  task automatic test_latency();
    for (int a = 0; a < 4; a++) cycle(1'b0, 1'b1, 9'(a), 64'((a + 1) * 10), 8'hFF, 1'b0, 9'd0);
    flush_q();
    for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'(a));
    idle(4);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cap_d[u].size() != exp_d[u].size()) $display("FAIL latency_beats u%0d: got %0d want %0d", u, cap_d[u].size(), exp_d[u].size());
      else passed++;
      for (int i = 0; i < exp_d[u].size() && i < cap_d[u].size(); i++) begin
        checks++;
        if (cap_d[u][i] !== exp_d[u][i] || cap_c[u][i] != exp_c[u][i])
          $display("FAIL latency_beat u%0d #%0d: got %h @%0d want %h @%0d", u, i, cap_d[u][i], cap_c[u][i], exp_d[u][i], exp_c[u][i]);
        else passed++;
      end
      checks++;
      if (r_valid[u] !== 1'b0 || r_data[u] !== 64'd40)
        $display("FAIL latency_hold u%0d: valid=%b data=%h want valid=0 data=%h", u, r_valid[u], r_data[u], 64'd40);
      else passed++;
    end
  endtask

  task automatic test_rdw();
    cycle(1'b0, 1'b1, 9'd5, 64'h0, 8'hFF, 1'b0, 9'd0);
    flush_q();
    cycle(1'b0, 1'b1, 9'd5, 64'hDEAD_BEEF_0000_1234, 8'h03, 1'b1, 9'd5);
    idle(4);
    for (int u = 0; u < 2; u++) begin
      logic [63:0] want;
      want = (u == 0) ? 64'h0000_0000_0000_1234 : 64'h0;
      checks++;
      if (cap_d[u].size() != 1) $display("FAIL rdw_beats u%0d: got %0d want 1", u, cap_d[u].size());
      else if (cap_d[u][0] !== want || cap_c[u][0] != exp_c[u][0])
        $display("FAIL rdw_data u%0d: got %h @%0d want %h @%0d", u, cap_d[u][0], cap_c[u][0], want, exp_c[u][0]);
      else passed++;
    end
  endtask

  task automatic test_out_of_range();
    cycle(1'b0, 1'b1, 9'd144, 64'h0144_0144_0144_0144, 8'hFF, 1'b0, 9'd0);
    flush_q();
    cycle(1'b0, 1'b1, 9'd400, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 9'd0);
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd400);
    cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'd144);
    idle(4);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cap_d[u].size() != 2) $display("FAIL oor_beats u%0d: got %0d want 2", u, cap_d[u].size());
      else passed++;
      for (int i = 0; i < 2 && i < cap_d[u].size(); i++) begin
        checks++;
        if (cap_d[u][i] !== exp_d[u][i] || cap_c[u][i] != exp_c[u][i])
          $display("FAIL oor_read u%0d #%0d: got %h @%0d want %h @%0d", u, i, cap_d[u][i], cap_c[u][i], exp_d[u][i], exp_c[u][i]);
        else passed++;
      end
    end
    checks++;
    if (cap_d[1].size() != 2 || cap_d[1][0] !== 64'h0 || cap_d[1][1] !== 64'h0144_0144_0144_0144)
      $display("FAIL oor_small_depth: got %0d beats want 2 beats 0 then %h", cap_d[1].size(), 64'h0144_0144_0144_0144);
    else passed++;
  endtask

  task automatic test_random();
    flush_q();
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 319)), {$urandom, $urandom},
            8'($urandom), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 319)));
    end
    idle(4);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cap_d[u].size() != exp_d[u].size()) $display("FAIL random_beats u%0d: got %0d want %0d", u, cap_d[u].size(), exp_d[u].size());
      else passed++;
      for (int i = 0; i < exp_d[u].size() && i < cap_d[u].size(); i++) begin
        checks++;
        if (cap_d[u][i] !== exp_d[u][i] || cap_c[u][i] != exp_c[u][i])
          $display("FAIL random_beat u%0d #%0d: got %h @%0d want %h @%0d", u, i, cap_d[u][i], cap_c[u][i], exp_d[u][i], exp_c[u][i]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_init();
    int cnt [2];
    cnt[0] = 0; cnt[1] = 0;
    cycle(1'b1, 1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
    cycle(1'b1, 1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
    idle(100);
    checks++;
    if (busy !== 2'b11) $display("FAIL midinit_busy: got %b want 11", busy);
    else passed++;
    cycle(1'b1, 1'b0, 9'd0, 64'd0, 8'd0, 1'b0, 9'd0);
    flush_q();
    for (int k = 0; k < 700 && busy != 2'b00; k++) begin
      for (int u = 0; u < 2; u++) if (busy[u] === 1'b1) cnt[u]++;
      idle(1);
    end
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cnt[u] != depth_of(u)) $display("FAIL midinit_busy_len u%0d: got %0d want %0d", u, cnt[u], depth_of(u));
      else passed++;
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 9'd0, 64'd0, 8'd0, 1'b1, 9'($urandom_range(0, 299)));
    idle(4);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (cap_d[u].size() != exp_d[u].size()) $display("FAIL midinit_beats u%0d: got %0d want %0d", u, cap_d[u].size(), exp_d[u].size());
      else passed++;
      for (int i = 0; i < exp_d[u].size() && i < cap_d[u].size(); i++) begin
        checks++;
        if (cap_d[u][i] !== exp_d[u][i] || cap_c[u][i] != exp_c[u][i])
          $display("FAIL midinit_read u%0d #%0d: got %h @%0d want %h @%0d", u, i, cap_d[u][i], cap_c[u][i], exp_d[u][i], exp_c[u][i]);
        else passed++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    init_left[0] = 0; init_left[1] = 0;
    rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0; r_en = 1'b0; r_addr = '0;
    test_reset();
    test_clear();
    test_masked();
    test_latency();
    test_rdw();
    test_out_of_range();
    test_random();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
